// File: rtl/write_vec_p_pkg.sv
// Shared types and defaults for the banked vector writer.
package vec_pkg;
    localparam int W_DEF = 10;
    localparam int D_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wr_state_t;

    typedef logic [W_DEF-1:0] elem_t;
endpackage

// File: rtl/write_vec_p_if.sv
// Command and element stream bundle between producer and vector writer.
interface write_vec_p_if
    import vec_pkg::*;
#(
    parameter int WIDTH = W_DEF,
    parameter int DEPTH = D_DEF
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = $clog2(DEPTH + 1);

    logic              start;
    logic              sel;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              active_sel;

    modport master (
        output start, sel, base, len, in_valid, in_data,
        input  in_ready, busy, done, active_sel
    );

    modport slave (
        input  start, sel, base, len, in_valid, in_data,
        output in_ready, busy, done, active_sel
    );
endinterface

// File: rtl/write_vec_p_bank_reg.sv
// One register bank: synchronous clear, single write port, packed view.
module vec_bank_reg
    import vec_pkg::*;
#(
    parameter int WIDTH  = W_DEF,
    parameter int DEPTH  = D_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [DEPTH-1:0][WIDTH-1:0]  q_o
);
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[addr_i] <= data_i;
        end
    end

    assign q_o = mem_q;
endmodule

// File: rtl/write_vec_p.sv
// Streams elements into consecutive slots of bank A or B.
module write_vec_p
    import vec_pkg::*;
#(
    parameter int WIDTH = W_DEF,
    parameter int DEPTH = D_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    write_vec_p_if.slave                bus,
    output logic [DEPTH-1:0][WIDTH-1:0] out_A,
    output logic [DEPTH-1:0][WIDTH-1:0] out_B
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = $clog2(DEPTH + 1);

    wr_state_t         state_q, state_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sel_d   = bus.sel;
                    ptr_d   = bus.base;
                    rem_d   = bus.len;
                    state_d = (bus.len == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (bus.in_valid) begin
                    we    = 1'b1;
                    // Pointer wraps naturally since DEPTH is a power of two
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.in_ready   = (state_q == WRITE);
    assign bus.done       = (state_q == DONE);
    assign bus.active_sel = sel_q;

    vec_bank_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (we & ~sel_q),
        .addr_i (ptr_q),
        .data_i (bus.in_data),
        .q_o    (out_A)
    );

    vec_bank_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (we & sel_q),
        .addr_i (ptr_q),
        .data_i (bus.in_data),
        .q_o    (out_B)
    );
endmodule

// File: tb/tb_write_vec_p.sv
// Scoreboard bench for write_vec_p with a small DEPTH=8 configuration.
module tb_write_vec_p;
    localparam int WIDTH  = 10;
    localparam int DEPTH  = 8;
    localparam int VW     = DEPTH * WIDTH;

    typedef struct {
        int           cyc;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic          sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [DEPTH-1:0][WIDTH-1:0] out_a, out_b;
    logic [WIDTH-1:0] mA [DEPTH];
    logic [WIDTH-1:0] mB [DEPTH];
    logic [WIDTH-1:0] stim_q [$];
    exp_t exp_q [$];

    write_vec_p_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    write_vec_p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .out_A (out_a),
        .out_B (out_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n && bus.start && !bus.busy)
            assert (int'(bus.len) <= DEPTH)
            else $error("illegal len %0d", bus.len);
    end

    task automatic check(input string nm, input logic [VW-1:0] got,
                         input logic [VW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic logic [VW-1:0] pack_a();
        logic [VW-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = mA[i];
        return v;
    endfunction

    function automatic logic [VW-1:0] pack_b();
        logic [VW-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = mB[i];
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding command
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected cyc=%0d got=1 want=0", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", VW'(cyc), VW'(e.cyc));
                check("bank_a", out_a, e.a);
                check("bank_b", out_b, e.b);
                check("active_sel", VW'(bus.active_sel), VW'(e.sel));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL idle_timeout got=busy want=idle");
        end
    endtask

    task automatic run_cmd(input bit s, input int b, input int l,
                           input int stall_at, input int stall_n,
                           input bit intrude);
        exp_t e;
        wait_idle();
        @(posedge clk); #1;
        for (int i = 0; i < l; i++) begin
            if (s) mB[(b + i) % DEPTH] = stim_q[i];
            else   mA[(b + i) % DEPTH] = stim_q[i];
        end
        e.cyc = cyc + 1 + l + ((stall_at < l) ? stall_n : 0);
        e.a   = pack_a();
        e.b   = pack_b();
        e.sel = s;
        exp_q.push_back(e);
        bus.start    = 1'b1;
        bus.sel      = s;
        bus.base     = 3'(b);
        bus.len      = 4'(l);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < l; i++) begin
            int n = 0;
            if (i == stall_at) begin
                repeat (stall_n) begin
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                    check("stall_ready", VW'(bus.in_ready), VW'(1));
                    @(posedge clk); #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[i];
            if (intrude && i == 1) begin
                bus.start = 1'b1;
                bus.sel   = 1'b1;
                bus.base  = '0;
                bus.len   = 4'd1;
            end
            @(negedge clk);
            while (!bus.in_ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            if (n >= 20) begin
                total++;
                bad++;
                $display("FAIL ready_timeout got=0 want=1");
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic fill_rand(input int l);
        stim_q = {};
        for (int i = 0; i < l; i++) stim_q.push_back(WIDTH'($urandom));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.sel      = 1'b0;
        bus.base     = '0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mA[i] = '0;
            mB[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_a", out_a, '0);
        check("rst_out_b", out_b, '0);
        check("rst_busy", VW'(bus.busy), '0);
        check("rst_ready", VW'(bus.in_ready), '0);
        check("rst_done", VW'(bus.done), '0);

        stim_q = {10'h11, 10'h22, 10'h33};
        run_cmd(1'b0, 2, 3, 99, 0, 1'b0);

        stim_q = {10'd1, 10'd2, 10'd3, 10'd4};
        run_cmd(1'b1, 6, 4, 99, 0, 1'b0);

        stim_q = {10'h11, 10'h22, 10'h33};
        run_cmd(1'b0, 2, 3, 1, 5, 1'b0);

        fill_rand(3);
        run_cmd(1'b0, 5, 3, 99, 0, 1'b1);

        stim_q = {};
        run_cmd(1'b1, 3, 0, 99, 0, 1'b0);

        // Reset after two of three elements
        wait_idle();
        @(posedge clk); #1;
        fill_rand(3);
        bus.start = 1'b1;
        bus.sel   = 1'b1;
        bus.base  = 3'd1;
        bus.len   = 4'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            mA[i] = '0;
            mB[i] = '0;
        end
        @(negedge clk);
        check("mid_rst_a", out_a, '0);
        check("mid_rst_b", out_b, '0);
        check("mid_rst_busy", VW'(bus.busy), '0);
        check("mid_rst_ready", VW'(bus.in_ready), '0);
        check("mid_rst_done", VW'(bus.done), '0);

        fill_rand(DEPTH);
        run_cmd(1'b1, 5, DEPTH, 99, 0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            int l, sa;
            l  = $urandom_range(0, DEPTH);
            sa = $urandom_range(0, l);
            fill_rand(l);
            run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                    l, sa, $urandom_range(0, 3), 1'b0);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("pending_done", VW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/write_vec_p.md
Name: write_vec_p

Overview:
Streaming writer for the coprocessor's double-banked vector register storage. A command selects bank A or B, a start index and an element count. Elements then arrive over a valid/ready stream and are written one per cycle into consecutive slots of the selected bank. Both banks are exposed as packed vectors so the downstream bank-select read path consumes them directly.

Parameters:
WIDTH, 10, bits per vector element
DEPTH, 1024, elements per bank; must be a power of two
ADDR_W, $clog2(DEPTH), element index width (derived, not overridden)
LEN_W, $clog2(DEPTH+1), element count width (derived, not overridden)

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  command strobe, accepted only when busy=0
sel  input  1  target bank at command: 0=A, 1=B
base  input  ADDR_W  first element index
len  input  LEN_W  number of elements to write, 0..DEPTH
in_valid  input  1  stream element valid
in_data  input  WIDTH  stream element
in_ready  output  1  writer accepts element this cycle
busy  output  1  command in progress
done  output  1  one-cycle pulse on command completion
active_sel  output  1  bank of the current/last command
out_A  output  DEPTH*WIDTH  packed bank A, [DEPTH-1:0][WIDTH-1:0]
out_B  output  DEPTH*WIDTH  packed bank B, same layout

Behaviour:
- Reset (rst_n=0 at a clock edge) applies to both banks and all outputs: all elements 0, in_ready=0, busy=0, done=0, active_sel=0, state IDLE. Reset overrides any command or transfer in progress. A partial write is discarded, because the banks are cleared.
- FSM states: IDLE, WRITE, DONE (enum in package).
- IDLE: busy=0, in_ready=0.
  - start=1 latches sel into active_sel, base into the write pointer, and len into the remaining counter.
  - Next state is WRITE if len!=0, or DONE if len==0. A len==0 command writes nothing.
- start is ignored while busy=1 (WRITE or DONE). It is not queued.
- WRITE: busy=1, in_ready=1 (combinational from state only; never depends on in_valid).
  - A transfer occurs on a cycle with in_valid && in_ready. in_data is written to bank[active_sel][ptr], then ptr increments and remaining decrements.
  - The write is visible on out_A/out_B the cycle after the handshake.
  - ptr wraps modulo DEPTH: DEPTH-1 -> 0. base+len > DEPTH wraps to the bank start and does not raise an error.
  - When the transfer with remaining==1 completes, the next state is DONE.
  - in_valid=0 stalls indefinitely with no state change.
  - len==DEPTH rewrites every slot exactly once.
- DONE: busy=1, in_ready=0, done=1 for exactly this one cycle. Next state is IDLE.
  - Minimum command-to-done latency is len+1 cycles after the start cycle, with in_valid held high.
- The unselected bank is never modified by a command.
- out_A and out_B are pure register outputs, with no combinational path from inputs.
- len > DEPTH is illegal. The bench asserts it never occurs; RTL behaviour for it is unspecified.

Decomposition:
- Package vec_pkg holds:
  - WIDTH and DEPTH defaults;
  - a wr_state_t enum {IDLE, WRITE, DONE};
  - an element type, logic [WIDTH-1:0].
- Natural sub-module vec_bank_reg: one DEPTH x WIDTH register bank with a synchronous active-low clear, a single write port (we, addr, data) and a packed output. It is instantiated twice. we is gated by active_sel.
- FSM, pointer and counter stay in write_vec_p.

Test Plan:
1. Reset, then idle: out_A=out_B=0, busy=0, in_ready=0, done=0.
2. DEPTH=8, sel=0, base=2, len=3, stream 0x11,0x22,0x33 with in_valid high:
   - out_A[2..4]=0x11,0x22,0x33; all other out_A slots and all of out_B stay 0;
   - done pulses 4 cycles after start.
3. DEPTH=8, sel=1, base=6, len=4, data 1,2,3,4:
   - wrap gives out_B[6]=1, [7]=2, [0]=3, [1]=4; out_A unchanged.
4. Stall: same as case 2 with in_valid low for 5 cycles between elements 1 and 2:
   - in_ready stays 1, no extra writes, done is delayed by exactly 5 cycles.
5. start pulsed during WRITE with sel=1, base=0, len=1:
   - ignored; out_B unchanged; the original command completes normally.
   - len=0 command: done pulses the cycle after start, and no bank changes.
6. rst_n=0 mid-transfer after 2 of 3 elements:
   - next cycle both banks are 0, busy=0, in_ready=0, no done pulse;
   - a new command afterwards works normally.
